serializer16: RTL and testbench
===============================

SERIALIZER16 -- requirements
Module: serializer16

Interface
REQ-001 SHALL have parameter: WIDTH, 16, number of bits per frame (legal range 2..32).
REQ-002 SHALL have parameter: MSB_FIRST, 1, bit order (1 = bit WIDTH-1 first, 0 = bit 0 first).
REQ-003 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: load  input  1  frame request; sampled on the rising edge of clock.
REQ-006 SHALL have port: data  input  WIDTH  parallel word; captured when load is accepted.
REQ-007 SHALL have port: ready  output  1  high when a load on this edge will be accepted.
REQ-008 SHALL have port: sout  output  1  serial bit stream to the downstream delay line.
REQ-009 SHALL have port: valid  output  1  high while sout carries a frame bit.
REQ-010 SHALL have port: busy  output  1  high while a frame is in progress.
REQ-011 SHALL have port: done  output  1  one-cycle pulse coincident with the last bit of a frame.

Function
REQ-012 SHALL implement exactly two states, IDLE and SHIFT, with a shift register of WIDTH bits and a bit counter of ceil(log2(WIDTH)) bits.
REQ-013 sout, valid, busy and done SHALL be driven directly from flops.
REQ-014 ready SHALL equal (state == IDLE) OR (done == 1), with no other terms.
REQ-015 IDLE: sout=0, valid=0, busy=0, done=0.
REQ-016 IDLE, load=1 at edge N: the block SHALL capture data, enter SHIFT and set counter=0. The first bit SHALL appear on sout in the cycle after edge N, with valid=1 and busy=1.
REQ-017 SHIFT: the block SHALL present exactly one new bit per cycle. Bits SHALL appear in cycles N+1 .. N+WIDTH, in the order set by MSB_FIRST.
REQ-018 done SHALL be 1 only in cycle N+WIDTH, which carries the last bit.
REQ-019 Last-bit cycle, load=0: the block SHALL return to IDLE on the next edge. The following cycle SHALL have sout=0, valid=0, busy=0.
REQ-020 Last-bit cycle, load=1: the block SHALL capture the new data and stay in SHIFT. The first bit of the new frame SHALL follow with no gap, so valid stays 1 continuously.
REQ-021 load=1 while in SHIFT and not in the last-bit cycle SHALL be ignored. The shift register, counter and data SHALL be unaffected.
REQ-022 data SHALL be sampled only on the accepting edge. Later changes to data SHALL NOT alter the frame in flight.
REQ-023 The counter SHALL wrap to 0 only on frame completion. No other wrap SHALL occur.

Reset
REQ-024 reset=1 at an edge SHALL force state=IDLE, counter=0, shift register=0, and sout=0, valid=0, busy=0, done=0 in the following cycle.
REQ-025 reset SHALL take priority over load. A load asserted in the same edge as reset SHALL be dropped.
REQ-026 reset mid-frame SHALL abort the frame with no further bits emitted. A load after reset deasserts SHALL start a fresh frame per REQ-016.
REQ-027 ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-028 Default parameters, data=16'h3380, load pulse at edge N -> sout over N+1..N+16 = 0011001110000000; valid=1 throughout; done=1 only at N+16; idle at N+17.
REQ-029 MSB_FIRST=0, data=16'h0001 -> first sout bit=1, remaining 15 bits=0; done on bit 16.
REQ-030 Back-to-back: 16'hFFFF then 16'h0000, second load held during the done cycle -> 32 contiguous valid cycles, 16 ones then 16 zeros; done pulses at cycles 16 and 32.
REQ-031 Load with 16'hAAAA at bit 5 of a 16'h3380 frame -> ignored; the frame completes as 3380; ready=0 during cycles 1..15.
REQ-032 reset asserted during bit 5 -> next cycle sout=valid=busy=done=0; a subsequent load of 16'h8001 emits 1000000000000001 cleanly.
REQ-033 Chained into the 16-stage downstream delay line with data=16'h3380 -> the delay-line output reproduces 0011001110000000 exactly 16 cycles after sout.

Source files
------------

// File: rtl/serializer16.sv
// ----------------------------------------------------------------------------
// serializer16 : parallel-to-serial frame shifter with done-cycle reload
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serializer16 #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             sout,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_PENULT = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    count_q;
  logic             sout_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic             first_bit_d;
  logic [WIDTH-1:0] load_shreg_d;
  logic             next_bit_d;
  logic [WIDTH-1:0] next_shreg_d;

  // The bit leaving next always sits at the output end of the shift register.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign first_bit_d  = data[WIDTH-1];
      assign load_shreg_d = {data[WIDTH-2:0], 1'b0};
      assign next_bit_d   = shreg_q[WIDTH-1];
      assign next_shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign first_bit_d  = data[0];
      assign load_shreg_d = {1'b0, data[WIDTH-1:1]};
      assign next_bit_d   = shreg_q[0];
      assign next_shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if ((state_q == IDLE || done_q) && load) begin
      // Accept from idle or during the last bit, giving a gapless next frame.
      state_q <= SHIFT;
      shreg_q <= load_shreg_d;
      count_q <= '0;
      sout_q  <= first_bit_d;
      valid_q <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (state_q == SHIFT && done_q) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (state_q == SHIFT) begin
      shreg_q <= next_shreg_d;
      count_q <= count_q + 1'b1;
      sout_q  <= next_bit_d;
      done_q  <= (count_q == C_PENULT);
    end
  end

  assign ready = (state_q == IDLE) || done_q;
  assign sout  = sout_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serializer16.sv
// ----------------------------------------------------------------------------
// tb_serializer16 : randomized and directed checks against a frame-level model
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serializer16;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         load  = 1'b0;
  logic [W-1:0] data  = '0;

  logic ready_m, sout_m, valid_m, busy_m, done_m;
  logic ready_l, sout_l, valid_l, busy_l, done_l;

  always #5 clock = ~clock;

  serializer16 #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clock(clock), .reset(reset), .load(load), .data(data),
    .ready(ready_m), .sout(sout_m), .valid(valid_m), .busy(busy_m), .done(done_m)
  );

  serializer16 #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clock(clock), .reset(reset), .load(load), .data(data),
    .ready(ready_l), .sout(sout_l), .valid(valid_l), .busy(busy_l), .done(done_l)
  );

  // Downstream 16-stage delay line fed by the MSB-first serial stream.
  logic [15:0] dline = '0;
  always @(posedge clock) dline <= {dline[14:0], sout_m};

  int errors = 0;
  int checks = 0;

  // Model: pos = number of frame bits shown so far, 0 when idle.
  int           pos       = 0;
  logic [W-1:0] frame     = '0;
  bit           chk_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit ld, input logic [W-1:0] d);
    bit exp_ready;
    reset = rst;
    load  = ld;
    data  = d;
    exp_ready = (pos == 0) || (pos == W);
    if (chk_ready) begin
      check("ready_m", {31'b0, ready_m}, {31'b0, exp_ready});
      check("ready_l", {31'b0, ready_l}, {31'b0, exp_ready});
    end
    @(posedge clock);
    if (rst)                   pos = 0;
    else if (ld && exp_ready) begin frame = d; pos = 1; end
    else if (pos == W)         pos = 0;
    else if (pos > 0)          pos = pos + 1;
    #1;
    chk_ready = 1'b1;
    check("sout_m",  {31'b0, sout_m},  {31'b0, (pos > 0) ? frame[W - pos] : 1'b0});
    check("sout_l",  {31'b0, sout_l},  {31'b0, (pos > 0) ? frame[pos - 1] : 1'b0});
    check("valid_m", {31'b0, valid_m}, {31'b0, pos > 0});
    check("valid_l", {31'b0, valid_l}, {31'b0, pos > 0});
    check("busy_m",  {31'b0, busy_m},  {31'b0, pos > 0});
    check("busy_l",  {31'b0, busy_l},  {31'b0, pos > 0});
    check("done_m",  {31'b0, done_m},  {31'b0, pos == W});
    check("done_l",  {31'b0, done_l},  {31'b0, pos == W});
  endtask

  initial begin
    logic [31:0] vm;
    logic [31:0] vl;
    int          ndone;
    int          nvalid;

    // Reset state
    step(1'b1, 1'b1, 16'hFFFF);
    check("reset_valid", {31'b0, valid_m}, 32'd0);

    // Default frame 3380, MSB first; LSB-first instance sees reversed order
    step(1'b0, 1'b0, '0);
    vm = '0; vl = '0; ndone = 0;
    step(1'b0, 1'b1, 16'h3380);
    vm = {vm[30:0], sout_m}; vl = {vl[30:0], sout_l}; ndone += int'(done_m);
    repeat (15) begin
      step(1'b0, 1'b0, W'($urandom));
      vm = {vm[30:0], sout_m}; vl = {vl[30:0], sout_l}; ndone += int'(done_m);
    end
    check("f3380_bits", vm, 32'h0000_3380);
    check("f3380_lsb",  vl, 32'h0000_01CC);
    check("f3380_done_last", {31'b0, done_m}, 32'd1);
    check("f3380_done_cnt", ndone, 32'd1);
    step(1'b0, 1'b0, '0);
    check("f3380_idle", {29'b0, sout_m, valid_m, busy_m}, 32'd0);

    // LSB-first single bit
    vl = '0;
    step(1'b0, 1'b1, 16'h0001);
    vl = {vl[30:0], sout_l};
    repeat (15) begin
      step(1'b0, 1'b0, '0);
      vl = {vl[30:0], sout_l};
    end
    check("lsb_0001", vl, 32'h0000_8000);
    check("lsb_0001_done", {31'b0, done_l}, 32'd1);

    // Back-to-back FFFF then 0000, reload held in the done cycle
    step(1'b0, 1'b0, '0);
    vm = '0; ndone = 0; nvalid = 0;
    for (int i = 1; i <= 32; i++) begin
      if (i == 1)       step(1'b0, 1'b1, 16'hFFFF);
      else if (i == 17) step(1'b0, 1'b1, 16'h0000);
      else              step(1'b0, 1'b0, 16'h5A5A);
      vm = {vm[30:0], sout_m};
      nvalid += int'(valid_m);
      if (done_m) ndone += (i == 16 || i == 32) ? 1 : 100;
    end
    check("b2b_bits", vm, 32'hFFFF_0000);
    check("b2b_valid", nvalid, 32'd32);
    check("b2b_done", ndone, 32'd2);

    // Mid-frame load ignored, ready low during bits 1..15
    step(1'b0, 1'b0, '0);
    vm = '0; nvalid = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 1)      step(1'b0, 1'b1, 16'h3380);
      else if (i == 6) step(1'b0, 1'b1, 16'hAAAA);
      else             step(1'b0, 1'b0, 16'hAAAA);
      vm = {vm[30:0], sout_m};
      if (i < 16) nvalid += int'(ready_m);
    end
    check("ignore_bits", vm, 32'h0000_3380);
    check("ignore_ready", nvalid, 32'd0);

    // Reset during bit 5 aborts the frame, then a clean 8001 frame
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 16'h3380);
    repeat (4) step(1'b0, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 16'hFFFF);
    check("abort_outs", {28'b0, sout_m, valid_m, busy_m, done_m}, 32'd0);
    vm = '0;
    step(1'b0, 1'b1, 16'h8001);
    vm = {vm[30:0], sout_m};
    repeat (15) begin
      step(1'b0, 1'b0, '0);
      vm = {vm[30:0], sout_m};
    end
    check("post_reset_8001", vm, 32'h0000_8001);

    // Delay line reproduces the 3380 pattern 16 cycles later
    step(1'b0, 1'b0, '0);
    vm = '0;
    step(1'b0, 1'b1, 16'h3380);
    for (int i = 2; i <= 32; i++) begin
      step(1'b0, 1'b0, '0);
      if (i >= 17) vm = {vm[30:0], dline[15]};
    end
    check("dline_3380", vm, 32'h0000_3380);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
